serial_subtractor: RTL



---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first a - b over WIDTH cycles using a
// half-subtractor pair per bit and a registered borrow.
// Optional build macro SERIAL_SUB_SAT_EN: clamp diff to 0 when the final
// borrow is 1 (unsigned saturation); borrow_out still reports the borrow.
//
// Handshake: start is sampled only while IDLE (busy=0); the edge that sees
// start=1 captures a/b. busy is high from that edge until one cycle after
// done. done is a one-cycle pulse and diff/borrow_out are valid from the done
// cycle on, holding until the next completed operation. start seen while
// busy is ignored, not queued.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_shift;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             last_bit;
  logic             t_bit;
  logic             b1;
  logic             b2;
  logic             d_bit;
  logic             br_next;

  assign state_dbg = state;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  // Two cascaded half-subtractors on the current LSB plus the stored borrow.
  always_comb begin
    t_bit     = a_sr[0] ^ b_sr[0];
    b1        = ~a_sr[0] & b_sr[0];
    d_bit     = t_bit ^ br;
    b2        = ~t_bit & br;
    br_next   = b1 | b2;
    res_shift = {d_bit, res_sr[WIDTH-1:1]};
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT for WIDTH bits, DONE once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with registered busy/done so outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Operand capture, bit-serial shifting and final result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_shift;
          br     <= br_next;
          // The counter stops at WIDTH-1 instead of wrapping.
          if (!last_bit) begin
            cnt <= cnt + CW'(1);
          end else begin
`ifdef SERIAL_SUB_SAT_EN
            diff <= br_next ? '0 : res_shift;
`else
            diff <= res_shift;
`endif
            borrow_out <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
